// File: rtl/ahb_sram_responder_pkg.sv
// Shared AHB-Lite bus types for the SRAM responder and other slaves.
// Also holds the byte-lane and alignment helpers.
package ahb_sram_responder_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } transfer_kind_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } transfer_size_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } responder_state_t;

    localparam int unsigned WAIT_CNT_W = 4;

    // Little-endian lane enables; an unsupported size enables nothing.
    function automatic logic [3:0] lane_enable(transfer_size_t size, logic [1:0] lsb);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lsb;
            SIZE_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic bad_shape(transfer_size_t size, logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lsb[0];
            SIZE_WORD: bad = (lsb != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// Bus-side signals of one AHB-Lite device slot, as seen by the controller
// (master) and by the responder (slave).
interface ahb_sram_responder_if;
    import ahb_sram_responder_pkg::*;

    logic               sel;
    logic               write;
    logic [31:0]        addr;
    transfer_kind_t     trans;
    transfer_size_t     size;
    logic [31:0]        wdata;
    logic               ready_in;
    logic [31:0]        rdata;
    logic               ready_out;
    transfer_response_t resp;

    modport master (
        output sel, write, addr, trans, size, wdata, ready_in,
        input  rdata, ready_out, resp
    );

    modport slave (
        input  sel, write, addr, trans, size, wdata, ready_in,
        output rdata, ready_out, resp
    );

endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised RAM with a byte-enable synchronous write port and a
// combinational read of the same word index.
module ahb_sram_array #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] word,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[word];

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: wait-state insertion, byte/half/word writes and
// the two-cycle ERROR response for out-of-range or malformed transfers.
module ahb_sram_responder
    import ahb_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb_sram_responder_if.slave  bus
);

    localparam int unsigned            AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0]            RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LOAD   = WAIT_CNT_W'(WAIT_STATES);

    responder_state_t        state;
    responder_state_t        state_nxt;
    logic [WAIT_CNT_W-1:0]   counter;
    logic [WAIT_CNT_W-1:0]   count_nxt;

    logic [31:0]             offset;
    logic                    accept;
    logic                    addr_err;
    logic                    take_new;
    logic                    capture;
    logic                    write_nxt;

    logic                    cap_write;
    transfer_size_t          cap_size;
    logic [AW-1:0]           cap_word;
    logic [1:0]              cap_lsb;

    logic                    ready_q;
    transfer_response_t      resp_q;
    logic                    rd_final;

    logic                    ram_we;
    logic [3:0]              ram_be;
    logic [31:0]             ram_rdata;

    // An address below BASE_ADDR wraps to a huge offset and lands in the range error.
    always_comb begin
        offset   = bus.addr - BASE_ADDR;
        accept   = bus.sel && bus.ready_in &&
                   (bus.trans == TRANS_NONSEQ || bus.trans == TRANS_SEQ);
        addr_err = ({1'b0, offset} >= RANGE_BYTES) || bad_shape(bus.size, bus.addr[1:0]);
    end

    // A new address phase is only taken when this slave is not mid data phase.
    always_comb begin
        state_nxt = state;
        count_nxt = counter;
        take_new  = 1'b0;
        case (state)
            ST_IDLE: take_new = 1'b1;
            ST_DATA: begin
                if (counter != '0) begin
                    count_nxt = counter - 1'b1;
                end else begin
                    take_new = 1'b1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: take_new = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase

        capture = take_new && accept;

        if (take_new) begin
            count_nxt = '0;
            if (!accept) begin
                state_nxt = ST_IDLE;
            end else if (addr_err) begin
                state_nxt = ST_ERR1;
            end else begin
                state_nxt = ST_DATA;
                count_nxt = WAIT_LOAD;
            end
        end

        write_nxt = capture ? bus.write : cap_write;
    end

    // Outputs are derived from the next state so they leave a flop directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            cap_write <= 1'b0;
            cap_size  <= SIZE_BYTE;
            cap_word  <= '0;
            cap_lsb   <= 2'b00;
            ready_q   <= 1'b1;
            resp_q    <= RESP_OKAY;
            rd_final  <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= count_nxt;
            if (capture) begin
                cap_write <= bus.write;
                cap_size  <= bus.size;
                cap_word  <= offset[AW+1:2];
                cap_lsb   <= bus.addr[1:0];
            end
            ready_q  <= !((state_nxt == ST_DATA && count_nxt != '0) || state_nxt == ST_ERR1);
            resp_q   <= (state_nxt == ST_ERR1 || state_nxt == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
            rd_final <= (state_nxt == ST_DATA) && (count_nxt == '0) && !write_nxt;
        end
    end

    // Gating with rst drops a write whose final edge coincides with reset.
    assign ram_we = rst && (state == ST_DATA) && (counter == '0) && cap_write;
    assign ram_be = lane_enable(cap_size, cap_lsb);

    ahb_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .word  (cap_word),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    assign bus.rdata     = rd_final ? ram_rdata : 32'h0;
    assign bus.ready_out = ready_q;
    assign bus.resp      = resp_q;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: two instances (0 and 1 wait states) checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_ahb_sram_responder;
    import ahb_sram_responder_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sel_v = 1'b0;
    logic           write_v = 1'b0;
    logic           stall_v = 1'b0;
    logic [31:0]    addr_v = 32'h0;
    logic [31:0]    wdata_v = 32'h0;
    transfer_kind_t trans_v = TRANS_IDLE;
    transfer_size_t size_v = SIZE_WORD;
    int             target = 1;
    int             total = 0;
    int             bad = 0;
    bit             chk_on = 1'b0;

    always #5 clk = ~clk;

    ahb_sram_responder_if if_ws0 ();
    ahb_sram_responder_if if_ws1 ();

    assign if_ws0.sel      = sel_v && (target == 0);
    assign if_ws0.write    = write_v;
    assign if_ws0.addr     = addr_v;
    assign if_ws0.trans    = trans_v;
    assign if_ws0.size     = size_v;
    assign if_ws0.wdata    = wdata_v;
    assign if_ws0.ready_in = if_ws0.ready_out & ~stall_v;

    assign if_ws1.sel      = sel_v && (target == 1);
    assign if_ws1.write    = write_v;
    assign if_ws1.addr     = addr_v;
    assign if_ws1.trans    = trans_v;
    assign if_ws1.size     = size_v;
    assign if_ws1.wdata    = wdata_v;
    assign if_ws1.ready_in = if_ws1.ready_out & ~stall_v;

    ahb_sram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0))
        dut_ws0 (.clk(clk), .rst(rst), .bus(if_ws0));
    ahb_sram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0))
        dut_ws1 (.clk(clk), .rst(rst), .bus(if_ws1));

    // One expected data-phase cycle of a transfer.
    typedef struct packed {
        logic       ready;
        logic       err;
        logic       fin_rd;
        logic       fin_wr;
        logic [9:0] word;
        logic [3:0] be;
    } rec_t;

    function automatic rec_t mk(logic r, logic e, logic rd, logic wr, logic [9:0] w, logic [3:0] b);
        rec_t x;
        x.ready = r; x.err = e; x.fin_rd = rd; x.fin_wr = wr; x.word = w; x.be = b;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Model index d has d wait states; it schedules each accepted transfer's cycles.
    for (genvar d = 0; d < 2; d++) begin : mdl
        rec_t        q[$];
        logic [31:0] mem [1024];
        logic        exp_ready = 1'b1;
        logic        exp_resp = 1'b0;
        logic [31:0] exp_rdata = 32'h0;

        always @(posedge clk) begin
            rec_t       cur;
            int         nbytes;
            logic [3:0] be;
            bit         acc;
            bit         err;
            if (!rst) begin
                q.delete();
            end else begin
                if (q.size() > 0) cur = q.pop_front();
                else              cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0);
                if (cur.fin_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (cur.be[b]) mem[cur.word][8*b +: 8] = wdata_v[8*b +: 8];
                end
                acc = (target == d) && sel_v && cur.ready && !stall_v &&
                      (trans_v == TRANS_NONSEQ || trans_v == TRANS_SEQ);
                if (acc) begin
                    nbytes = 1 << int'(size_v);
                    err = (addr_v >= 32'd4096) || (size_v == SIZE_RSVD) || ((addr_v % nbytes) != 0);
                    if (err) begin
                        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 4'd0));
                        q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 4'd0));
                    end else begin
                        be = 4'd0;
                        for (int b = 0; b < 4; b++)
                            if (b >= int'(addr_v[1:0]) && b < int'(addr_v[1:0]) + nbytes) be[b] = 1'b1;
                        for (int w = 0; w < d; w++)
                            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0));
                        q.push_back(mk(1'b1, 1'b0, !write_v, write_v, addr_v[11:2], be));
                    end
                end
            end
            if (q.size() > 0) begin
                exp_ready = q[0].ready;
                exp_resp  = q[0].err;
                exp_rdata = q[0].fin_rd ? mem[q[0].word] : 32'h0;
            end else begin
                exp_ready = 1'b1;
                exp_resp  = 1'b0;
                exp_rdata = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("ws0.ready_out", 32'(if_ws0.ready_out), 32'(mdl[0].exp_ready));
            checkOutput("ws0.resp",      32'(if_ws0.resp),      32'(mdl[0].exp_resp));
            checkOutput("ws0.rdata",     if_ws0.rdata,          mdl[0].exp_rdata);
            checkOutput("ws1.ready_out", 32'(if_ws1.ready_out), 32'(mdl[1].exp_ready));
            checkOutput("ws1.resp",      32'(if_ws1.resp),      32'(mdl[1].exp_resp));
            checkOutput("ws1.rdata",     if_ws1.rdata,          mdl[1].exp_rdata);
        end
    end

    function automatic logic [31:0] tgt_ready();
        return (target == 0) ? 32'(if_ws0.ready_out) : 32'(if_ws1.ready_out);
    endfunction
    function automatic logic [31:0] tgt_resp();
        return (target == 0) ? 32'(if_ws0.resp) : 32'(if_ws1.resp);
    endfunction
    function automatic logic [31:0] tgt_rdata();
        return (target == 0) ? if_ws0.rdata : if_ws1.rdata;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input transfer_kind_t t, input logic w,
                                 input logic [31:0] a, input transfer_size_t z, input logic [31:0] wd);
        sel_v = s; trans_v = t; write_v = w; addr_v = a; size_v = z; wdata_v = wd;
        step();
    endtask

    // Non-overlapped transfer on the current target; got is rdata of its final cycle.
    task automatic do_xfer(input logic w, input logic [31:0] a, input transfer_size_t z,
                           input logic [31:0] data, output logic [31:0] got);
        applyStimulus(1'b1, TRANS_NONSEQ, w, a, z, 32'h0);
        for (int i = 0; i < target; i++)
            applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, data);
        sel_v = 1'b0; trans_v = TRANS_IDLE; write_v = 1'b0; wdata_v = data;
        got = tgt_rdata();
        step();
    endtask

    task automatic do_error(input logic w, input logic [31:0] a, input transfer_size_t z, input string name);
        applyStimulus(1'b1, TRANS_NONSEQ, w, a, z, 32'h0);
        sel_v = 1'b0; trans_v = TRANS_IDLE; wdata_v = 32'hFFFF_FFFF;
        checkOutput({name, ".err1.ready"}, tgt_ready(), 32'd0);
        checkOutput({name, ".err1.resp"},  tgt_resp(),  32'd1);
        step();
        checkOutput({name, ".err2.ready"}, tgt_ready(), 32'd1);
        checkOutput({name, ".err2.resp"},  tgt_resp(),  32'd1);
        step();
    endtask

    initial begin
        logic [31:0] got;
        rst = 1'b0;
        target = 1;
        step();
        chk_on = 1'b1;
        step();
        checkOutput("reset.ready", tgt_ready(), 32'd1);
        checkOutput("reset.resp",  tgt_resp(),  32'd0);
        checkOutput("reset.rdata", tgt_rdata(), 32'd0);
        rst = 1'b1;

        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h10, SIZE_WORD, 32'h0);
        checkOutput("wr10.wait.ready", tgt_ready(), 32'd0);
        checkOutput("wr10.wait.resp",  tgt_resp(),  32'd0);
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'hDEAD_BEEF);
        checkOutput("wr10.final.ready", tgt_ready(), 32'd1);
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'hDEAD_BEEF);
        do_xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, got);
        checkOutput("rd10", got, 32'hDEAD_BEEF);

        do_xfer(1'b1, 32'h20, SIZE_WORD, 32'h1122_3344, got);
        do_xfer(1'b1, 32'h22, SIZE_BYTE, 32'h00AA_0000, got);
        do_xfer(1'b0, 32'h20, SIZE_WORD, 32'h0, got);
        checkOutput("byte_lane", got, 32'h11AA_3344);
        do_xfer(1'b1, 32'h22, SIZE_HALF, 32'hBEEF_0000, got);
        do_xfer(1'b0, 32'h20, SIZE_WORD, 32'h0, got);
        checkOutput("half_lane", got, 32'hBEEF_3344);

        do_xfer(1'b1, 32'h00, SIZE_WORD, 32'hCAFE_F00D, got);
        do_error(1'b1, 32'h1000, SIZE_WORD, "range");
        do_xfer(1'b0, 32'h00, SIZE_WORD, 32'h0, got);
        checkOutput("range.nowrite", got, 32'hCAFE_F00D);
        do_xfer(1'b1, 32'h04, SIZE_WORD, 32'h0102_0304, got);
        do_error(1'b1, 32'h06, SIZE_WORD, "misalign");
        do_xfer(1'b0, 32'h04, SIZE_WORD, 32'h0, got);
        checkOutput("misalign.nowrite", got, 32'h0102_0304);
        do_xfer(1'b1, 32'h08, SIZE_WORD, 32'h0A0B_0C0D, got);
        do_error(1'b1, 32'h08, SIZE_RSVD, "size3");
        do_xfer(1'b0, 32'h08, SIZE_WORD, 32'h0, got);
        checkOutput("size3.nowrite", got, 32'h0A0B_0C0D);
        do_error(1'b1, 32'h21, SIZE_HALF, "half_odd");
        do_error(1'b0, 32'h2000, SIZE_WORD, "rd_range");
        do_xfer(1'b0, 32'h20, SIZE_WORD, 32'h0, got);
        checkOutput("half_odd.nowrite", got, 32'hBEEF_3344);

        applyStimulus(1'b1, TRANS_IDLE, 1'b1, 32'h10, SIZE_WORD, 32'h5555_5555);
        checkOutput("filter.idle.ready", tgt_ready(), 32'd1);
        applyStimulus(1'b1, TRANS_BUSY, 1'b1, 32'h10, SIZE_WORD, 32'h5555_5555);
        checkOutput("filter.busy.ready", tgt_ready(), 32'd1);
        stall_v = 1'b1;
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h10, SIZE_WORD, 32'h5555_5555);
        stall_v = 1'b0;
        checkOutput("filter.stall.ready", tgt_ready(), 32'd1);
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h5555_5555);
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h5555_5555);
        do_xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, got);
        checkOutput("filter.nowrite", got, 32'hDEAD_BEEF);

        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h10, SIZE_WORD, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h0BAD_F00D);
        checkOutput("midreset.ready", tgt_ready(), 32'd1);
        checkOutput("midreset.resp",  tgt_resp(),  32'd0);
        checkOutput("midreset.rdata", tgt_rdata(), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h0BAD_F00D);
        do_xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, got);
        checkOutput("midreset.nowrite", got, 32'hDEAD_BEEF);

        target = 0;
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h40, SIZE_WORD, 32'h0);
        checkOutput("ws0.wr40.ready", tgt_ready(), 32'd1);
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, 32'h40, SIZE_WORD, 32'h1234_5678);
        checkOutput("ws0.rd40.ready", tgt_ready(), 32'd1);
        checkOutput("ws0.rd40.rdata", tgt_rdata(), 32'h1234_5678);
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h44, SIZE_WORD, 32'h0);
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, 32'h45, SIZE_BYTE, 32'hAABB_CCDD);
        applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, 32'h44, SIZE_WORD, 32'h0000_EE00);
        checkOutput("ws0.rd44.rdata", tgt_rdata(), 32'hAABB_EEDD);
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        do_error(1'b1, 32'hFFFF_FFF0, SIZE_WORD, "ws0.wrap");

        repeat (3) applyStimulus(1'b0, TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
